// File: rtl/core_pkg.sv
// Core-wide widths, memory control encodings and the MEM stage state enum.
package core_pkg;

   localparam int DATA_WIDTH     = 32;
   localparam int ADDR_WIDTH     = 32;
   localparam int RF_ADDR_WIDTH  = 5;
   localparam int CSR_ADDR_WIDTH = 12;
   localparam int BE_WIDTH       = DATA_WIDTH / 8;
   localparam int LANE_WIDTH     = $clog2(BE_WIDTH);

   typedef enum logic [1:0] {
      MEM_BYTE   = 2'd0,
      MEM_HALF   = 2'd1,
      MEM_WORD   = 2'd2,
      MEM_DOUBLE = 2'd3
   } mem_size_e;

   typedef struct packed {
      logic      load;
      logic      store;
      logic      sign_ext;
      mem_size_e size;
   } mem_ctrl_t;

   typedef struct packed {
      logic       we;
      logic [1:0] wb_sel;
   } gpr_ctrl_t;

   typedef struct packed {
      logic                      we;
      logic [CSR_ADDR_WIDTH-1:0] addr;
   } csr_ctrl_t;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } mem_state_e;

   // Natural alignment: half on even, word on 4, double on 8 byte boundaries.
   function automatic logic mem_misaligned(input mem_size_e size, input logic [2:0] lsb);
      logic mis;
      mis = 1'b0;
      case (size)
         MEM_HALF:   mis = lsb[0];
         MEM_WORD:   mis = |lsb[1:0];
         MEM_DOUBLE: mis = |lsb[2:0];
         default:    mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/exe2mem_pkg.sv
// EXE->MEM stage payload.
package exe2mem_pkg;

   import core_pkg::*;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]    exe_out;
      logic [DATA_WIDTH-1:0]    op3;
      logic [RF_ADDR_WIDTH-1:0] rd;
      gpr_ctrl_t                gpr_ctrl;
      csr_ctrl_t                csr_ctrl;
      mem_ctrl_t                mem_ctrl;
   } exe2mem_t;

endpackage

// File: rtl/mem2wb_pkg.sv
// MEM->WB stage payload; mem_ctrl travels along so Writeback can extract load data.
package mem2wb_pkg;

   import core_pkg::*;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]    exe_out;
      logic [DATA_WIDTH-1:0]    op3;
      logic [RF_ADDR_WIDTH-1:0] rd;
      gpr_ctrl_t                gpr_ctrl;
      csr_ctrl_t                csr_ctrl;
      mem_ctrl_t                mem_ctrl;
   } mem2wb_t;

endpackage

// File: rtl/memory_unit.sv
// Data bus formatting: byte enables, lane-shifted store data, aligned address, misalignment flag.
// Latency: combinational. Backpressure: none.
// MEM_MISALIGN_CHECK_EN enables the misalignment flag; otherwise it is tied 0.
module memory_unit
   import core_pkg::*;
(
   input  logic                  load,
   input  logic                  store,
   input  mem_size_e             size,
   input  logic [DATA_WIDTH-1:0] exe_out,
   input  logic [DATA_WIDTH-1:0] op3,
   output logic [BE_WIDTH-1:0]   be,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  misaligned
);

   logic [LANE_WIDTH-1:0] lane;
   logic [BE_WIDTH-1:0]   base_be;

   assign lane = exe_out[LANE_WIDTH-1:0];

   always_comb begin
      base_be = '0;
      case (size)
         MEM_BYTE: base_be = BE_WIDTH'(1);
         MEM_HALF: base_be = BE_WIDTH'(3);
         MEM_WORD: base_be = BE_WIDTH'(4'hF);
         default:  base_be = '1;
      endcase
   end

   // Shifting within BE_WIDTH bits truncates enables that would cross the bus.
   always_comb begin
      be = '0;
      if (store) begin
         be = base_be << lane;
      end else if (load) begin
         be = '1;
      end
   end

   assign wdata = op3 << {lane, 3'b000};
   assign addr  = {exe_out[ADDR_WIDTH-1:LANE_WIDTH], {LANE_WIDTH{1'b0}}};

`ifdef MEM_MISALIGN_CHECK_EN
   assign misaligned = (load | store) & mem_misaligned(size, exe_out[2:0]);
`else
   assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/memory.sv
// MEM stage: registers the EXE payload, issues data memory requests, hands uops to Writeback.
// Latency: 1 cycle, plus grant wait for loads/stores. Backpressure: ready_o low while a request awaits grant.
// MEM_MISALIGN_CHECK_EN: misaligned accesses complete without a request and raise misaligned_o.
module memory
   import core_pkg::*;
   import exe2mem_pkg::*;
   import mem2wb_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  exe_valid_i,
   output logic                  ready_o,
   input  exe2mem_t              exe2mem_i,
   output logic                  valid_o,
   output mem2wb_t               mem2wb_o,
   output logic                  d_m_req_o,
   input  logic                  d_m_gnt_i,
   output logic                  d_m_we_o,
   output logic [ADDR_WIDTH-1:0] d_m_addr_o,
   output logic [BE_WIDTH-1:0]   d_m_be_o,
   output logic [DATA_WIDTH-1:0] d_m_wdata_o,
   output logic                  misaligned_o
);

   exe2mem_t              exe2mem_q;
   logic                  valid_q;
   mem_state_e            state_q;
   mem_state_e            state_d;
   logic                  capture;
   logic                  in_is_mem;
   logic                  in_go_req;
   logic [BE_WIDTH-1:0]   be_raw;
   logic                  mis_raw;

   assign capture   = exe_valid_i & ready_o;
   assign in_is_mem = exe2mem_i.mem_ctrl.load | exe2mem_i.mem_ctrl.store;

`ifdef MEM_MISALIGN_CHECK_EN
   assign in_go_req = in_is_mem & ~mem_misaligned(exe2mem_i.mem_ctrl.size, exe2mem_i.exe_out[2:0]);
`else
   assign in_go_req = in_is_mem;
`endif

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q   <= IDLE;
         valid_q   <= 1'b0;
         exe2mem_q <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            exe2mem_q <= exe2mem_i;
            valid_q   <= 1'b1;
         end else if (valid_o) begin
            valid_q      <= 1'b0;
            exe2mem_q.rd <= '0;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      d_m_req_o = 1'b0;
      valid_o   = valid_q;
      case (state_q)
         IDLE: begin
            if (capture && in_go_req) state_d = REQ;
         end
         REQ: begin
            d_m_req_o = 1'b1;
            valid_o   = d_m_gnt_i;
            if (d_m_gnt_i) state_d = (capture && in_go_req) ? REQ : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign ready_o = ~valid_q | valid_o;

   memory_unit u_memory_unit (
      .load       (exe2mem_q.mem_ctrl.load),
      .store      (exe2mem_q.mem_ctrl.store),
      .size       (exe2mem_q.mem_ctrl.size),
      .exe_out    (exe2mem_q.exe_out),
      .op3        (exe2mem_q.op3),
      .be         (be_raw),
      .wdata      (d_m_wdata_o),
      .addr       (d_m_addr_o),
      .misaligned (mis_raw)
   );

   assign d_m_we_o     = d_m_req_o & exe2mem_q.mem_ctrl.store;
   assign d_m_be_o     = d_m_req_o ? be_raw : '0;
   assign misaligned_o = valid_q & mis_raw;

   // Anything not leaving this cycle becomes a nop towards Writeback.
   always_comb begin
      mem2wb_o.exe_out  = exe2mem_q.exe_out;
      mem2wb_o.op3      = exe2mem_q.op3;
      mem2wb_o.rd       = exe2mem_q.rd;
      mem2wb_o.gpr_ctrl = exe2mem_q.gpr_ctrl;
      mem2wb_o.csr_ctrl = exe2mem_q.csr_ctrl;
      mem2wb_o.mem_ctrl = exe2mem_q.mem_ctrl;
      if (!valid_o) begin
         mem2wb_o.rd          = '0;
         mem2wb_o.gpr_ctrl.we = 1'b0;
         mem2wb_o.csr_ctrl.we = 1'b0;
      end
      if (misaligned_o) begin
         mem2wb_o.gpr_ctrl.we = 1'b0;
      end
   end

endmodule

// File: tb/tb_memory.sv
// Directed bench for the MEM stage: ALU pass-through, stores with grant wait, back-to-back, reset abort.
module tb_memory;

   import core_pkg::*;
   import exe2mem_pkg::*;
   import mem2wb_pkg::*;

   logic                  clk_i = 1'b0;
   logic                  rstn_i;
   logic                  exe_valid_i;
   logic                  ready_o;
   exe2mem_t              exe2mem_i;
   logic                  valid_o;
   mem2wb_t               mem2wb_o;
   logic                  d_m_req_o;
   logic                  d_m_gnt_i;
   logic                  d_m_we_o;
   logic [ADDR_WIDTH-1:0] d_m_addr_o;
   logic [BE_WIDTH-1:0]   d_m_be_o;
   logic [DATA_WIDTH-1:0] d_m_wdata_o;
   logic                  misaligned_o;

   int checks = 0;
   int errors = 0;

   memory dut (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .exe_valid_i  (exe_valid_i),
      .ready_o      (ready_o),
      .exe2mem_i    (exe2mem_i),
      .valid_o      (valid_o),
      .mem2wb_o     (mem2wb_o),
      .d_m_req_o    (d_m_req_o),
      .d_m_gnt_i    (d_m_gnt_i),
      .d_m_we_o     (d_m_we_o),
      .d_m_addr_o   (d_m_addr_o),
      .d_m_be_o     (d_m_be_o),
      .d_m_wdata_o  (d_m_wdata_o),
      .misaligned_o (misaligned_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic exe2mem_t uop(input logic [4:0] rd, input logic [31:0] ea,
                                    input logic [31:0] op3, input logic gwe,
                                    input logic ld, input logic st, input mem_size_e sz);
      exe2mem_t u;
      u                = '0;
      u.rd             = rd;
      u.exe_out        = ea;
      u.op3            = op3;
      u.gpr_ctrl.we    = gwe;
      u.mem_ctrl.load  = ld;
      u.mem_ctrl.store = st;
      u.mem_ctrl.size  = sz;
      return u;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn_i      = 1'b0;
      exe_valid_i = 1'b0;
      d_m_gnt_i   = 1'b0;
      exe2mem_i   = '0;
      step();
      step();
      chk("rst_valid", valid_o, 0);
      chk("rst_req", d_m_req_o, 0);
      chk("rst_we", d_m_we_o, 0);
      chk("rst_be", d_m_be_o, 0);
      chk("rst_ready", ready_o, 1);
      chk("rst_mis", misaligned_o, 0);
      rstn_i = 1'b1;

      // ALU uop
      exe_valid_i = 1'b1;
      exe2mem_i   = uop(5'd5, 32'h1234, 32'h0, 1'b1, 1'b0, 1'b0, MEM_WORD);
      #1;
      chk("alu_ready", ready_o, 1);
      chk("alu_pre_valid", valid_o, 0);
      step();
      exe_valid_i = 1'b0;
      #1;
      chk("alu_valid", valid_o, 1);
      chk("alu_rd", mem2wb_o.rd, 5);
      chk("alu_exe_out", mem2wb_o.exe_out, 32'h1234);
      chk("alu_gpr_we", mem2wb_o.gpr_ctrl.we, 1);
      chk("alu_req", d_m_req_o, 0);
      step();
      chk("alu_after_valid", valid_o, 0);
      chk("alu_after_rd", mem2wb_o.rd, 0);
      chk("alu_after_we", mem2wb_o.gpr_ctrl.we, 0);
      chk("alu_after_req", d_m_req_o, 0);

      // Store word with three grant-less cycles
      exe_valid_i = 1'b1;
      exe2mem_i   = uop(5'd0, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, MEM_WORD);
      step();
      exe_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d_m_gnt_i = (i == 3);
         #1;
         chk($sformatf("sw_req%0d", i), d_m_req_o, 1);
         chk($sformatf("sw_addr%0d", i), d_m_addr_o, 32'h100);
         chk($sformatf("sw_be%0d", i), d_m_be_o, 4'hF);
         chk($sformatf("sw_we%0d", i), d_m_we_o, 1);
         chk($sformatf("sw_wdata%0d", i), d_m_wdata_o, 32'hDEADBEEF);
         chk($sformatf("sw_ready%0d", i), ready_o, (i == 3) ? 1 : 0);
         chk($sformatf("sw_valid%0d", i), valid_o, (i == 3) ? 1 : 0);
         step();
      end
      d_m_gnt_i = 1'b0;
      #1;
      chk("sw_done_req", d_m_req_o, 0);
      chk("sw_done_valid", valid_o, 0);

      // Store byte at 0x103, granted immediately
      exe_valid_i = 1'b1;
      exe2mem_i   = uop(5'd0, 32'h103, 32'hAB, 1'b0, 1'b0, 1'b1, MEM_BYTE);
      step();
      exe_valid_i = 1'b0;
      d_m_gnt_i   = 1'b1;
      #1;
      chk("sb_req", d_m_req_o, 1);
      chk("sb_be", d_m_be_o, 4'h8);
      chk("sb_wdata", d_m_wdata_o, 32'hAB000000);
      chk("sb_addr", d_m_addr_o, 32'h100);
      chk("sb_valid", valid_o, 1);
      step();
      d_m_gnt_i = 1'b0;
      #1;
      chk("sb_done_req", d_m_req_o, 0);

      // Back-to-back load, ALU, load
      d_m_gnt_i   = 1'b1;
      exe_valid_i = 1'b1;
      exe2mem_i   = uop(5'd1, 32'h200, 32'h0, 1'b1, 1'b1, 1'b0, MEM_WORD);
      #1;
      chk("b2b_c0_ready", ready_o, 1);
      step();
      exe2mem_i = uop(5'd2, 32'h55, 32'h0, 1'b1, 1'b0, 1'b0, MEM_WORD);
      #1;
      chk("b2b_c1_valid", valid_o, 1);
      chk("b2b_c1_rd", mem2wb_o.rd, 1);
      chk("b2b_c1_req", d_m_req_o, 1);
      chk("b2b_c1_we", d_m_we_o, 0);
      chk("b2b_c1_be", d_m_be_o, 4'hF);
      chk("b2b_c1_addr", d_m_addr_o, 32'h200);
      chk("b2b_c1_ready", ready_o, 1);
      step();
      exe2mem_i = uop(5'd3, 32'h204, 32'h0, 1'b1, 1'b1, 1'b0, MEM_WORD);
      #1;
      chk("b2b_c2_valid", valid_o, 1);
      chk("b2b_c2_rd", mem2wb_o.rd, 2);
      chk("b2b_c2_req", d_m_req_o, 0);
      chk("b2b_c2_ready", ready_o, 1);
      step();
      exe_valid_i = 1'b0;
      #1;
      chk("b2b_c3_valid", valid_o, 1);
      chk("b2b_c3_rd", mem2wb_o.rd, 3);
      chk("b2b_c3_req", d_m_req_o, 1);
      chk("b2b_c3_addr", d_m_addr_o, 32'h204);
      chk("b2b_c3_ready", ready_o, 1);
      step();
      d_m_gnt_i = 1'b0;
      #1;
      chk("b2b_done_valid", valid_o, 0);

      // Reset while waiting for grant
      exe_valid_i = 1'b1;
      exe2mem_i   = uop(5'd9, 32'h300, 32'h0, 1'b1, 1'b1, 1'b0, MEM_WORD);
      step();
      exe_valid_i = 1'b0;
      #1;
      chk("rq_wait_req", d_m_req_o, 1);
      chk("rq_wait_ready", ready_o, 0);
      rstn_i = 1'b0;
      step();
      chk("rq_rst_req", d_m_req_o, 0);
      chk("rq_rst_valid", valid_o, 0);
      chk("rq_rst_ready", ready_o, 1);
      rstn_i    = 1'b1;
      d_m_gnt_i = 1'b1;
      #1;
      chk("rq_gnt_valid", valid_o, 0);
      chk("rq_gnt_req", d_m_req_o, 0);
      step();
      chk("rq_gnt2_valid", valid_o, 0);
      chk("rq_gnt2_rd", mem2wb_o.rd, 0);
      d_m_gnt_i = 1'b0;

`ifdef MEM_MISALIGN_CHECK_EN
      // Misaligned half load completes without a request
      exe_valid_i = 1'b1;
      exe2mem_i   = uop(5'd7, 32'h101, 32'h0, 1'b1, 1'b1, 1'b0, MEM_HALF);
      step();
      exe_valid_i = 1'b0;
      #1;
      chk("mis_req", d_m_req_o, 0);
      chk("mis_flag", misaligned_o, 1);
      chk("mis_valid", valid_o, 1);
      chk("mis_gpr_we", mem2wb_o.gpr_ctrl.we, 0);
      step();
      chk("mis_after_flag", misaligned_o, 0);
      chk("mis_after_valid", valid_o, 0);
`else
      // Without the check: half load at 0x101 is issued aligned down
      exe_valid_i = 1'b1;
      exe2mem_i   = uop(5'd7, 32'h101, 32'h0, 1'b1, 1'b1, 1'b0, MEM_HALF);
      step();
      exe_valid_i = 1'b0;
      d_m_gnt_i   = 1'b1;
      #1;
      chk("lh_req", d_m_req_o, 1);
      chk("lh_addr", d_m_addr_o, 32'h100);
      chk("lh_be", d_m_be_o, 4'hF);
      chk("lh_mis", misaligned_o, 0);
      chk("lh_gpr_we", mem2wb_o.gpr_ctrl.we, 1);
      step();
      d_m_gnt_i = 1'b0;

      // Store half at 0x103: enables truncated at the bus edge
      exe_valid_i = 1'b1;
      exe2mem_i   = uop(5'd0, 32'h103, 32'hCAFE, 1'b0, 1'b0, 1'b1, MEM_HALF);
      step();
      exe_valid_i = 1'b0;
      d_m_gnt_i   = 1'b1;
      #1;
      chk("sh_be", d_m_be_o, 4'h8);
      chk("sh_wdata", d_m_wdata_o, 32'hFE000000);
      chk("sh_addr", d_m_addr_o, 32'h100);
      chk("sh_mis", misaligned_o, 0);
      step();
      d_m_gnt_i = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory.md
Name: memory

Overview:
- Memory (MEM) stage of the SCHOLAR RISC-V core. Sits between Execute and Writeback.
- Registers the EXE->MEM payload and issues load/store requests to the data memory port.
- Stalls Execute until the request is granted, then hands a mem2wb_t uop to Writeback.
- Load data returns on d_m_rdata one cycle after grant and is consumed directly by Writeback.

Parameters:
- None. Widths come from core_pkg: DATA_WIDTH, ADDR_WIDTH, RF_ADDR_WIDTH.

Ports:
- clk_i  input  1  system clock
- rstn_i  input  1  reset; synchronous, active-low
- exe_valid_i  input  1  EXE presents a valid uop
- ready_o  output  1  MEM can accept a uop this cycle
- exe2mem_i  input  exe2mem_t  EXE->MEM payload (exe_out, op3, rd, gpr_ctrl, csr_ctrl, mem_ctrl)
- valid_o  output  1  uop complete; drives Writeback mem_valid_i
- mem2wb_o  output  mem2wb_t  MEM->WB payload
- d_m_req_o  output  1  data memory request
- d_m_gnt_i  input  1  request accepted this cycle
- d_m_we_o  output  1  1: store, 0: load
- d_m_addr_o  output  ADDR_WIDTH  word-aligned address
- d_m_be_o  output  DATA_WIDTH/8  byte enables
- d_m_wdata_o  output  DATA_WIDTH  lane-aligned store data
- misaligned_o  output  1  misaligned access flagged (MEM_MISALIGN_CHECK_EN only; tied 0 otherwise)

Behaviour:
- Reset state (rstn_i low at a clk edge): exe2mem_q = 0, valid_q = 0, state = IDLE.
- Output values after reset: valid_o = 0, d_m_req_o = 0, d_m_we_o = 0, d_m_be_o = 0, ready_o = 1, misaligned_o = 0.
- Capture: on a clock edge with exe_valid_i & ready_o, load exe2mem_q and set valid_q.
- Release: when valid_o is high and no new uop is captured, clear valid_q and clear only exe2mem_q.rd.
- Writeback is always ready, so a completed uop leaves MEM in the same cycle.
- Memory access: is_mem = mem_ctrl load or store. Address = exe_out; store data = op3.
- FSM states:
  - IDLE: no uop, or a non-memory uop. valid_o = valid_q.
  - REQ: valid_q & is_mem. d_m_req_o = 1, held stable until d_m_gnt_i. valid_o = d_m_gnt_i.
- Transitions:
  - IDLE->REQ: a memory uop is captured.
  - REQ->REQ: d_m_gnt_i = 0 (request and all request fields held).
  - REQ->IDLE or REQ: on d_m_gnt_i; the next state depends on the uop captured the same cycle.
- Latency:
  - Non-memory uop: 1 cycle in MEM.
  - Memory uop: 1 cycle + grant wait (grant in the first cycle gives 1 cycle).
- ready_o = !valid_q | valid_o, so back-to-back uops proceed with no bubble.
- Byte enables and store data, with lane = addr[LSB-1:0]:
  - Byte: d_m_be_o = 1 << lane.
  - Half: d_m_be_o = 3 << lane.
  - Word: d_m_be_o = 'hF << lane.
  - Double (DATA_WIDTH = 64): d_m_be_o = all ones.
  - d_m_wdata_o = op3 << (8*lane).
  - d_m_addr_o = address with low lane bits cleared.
- Loads: d_m_be_o is all ones. Writeback_unit performs extraction and sign extension.
- Nop injection: while valid_o = 0, mem2wb_o.rd = 0 and the GPR/CSR write-enable controls are forced to 0.
- d_m_gnt_i outside REQ: ignored.
- Reset mid-request: request dropped and d_m_req_o = 0 next cycle. The memory must tolerate an abandoned request.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- Defined:
  - Misaligned access (half on odd address, word not 4-aligned, double not 8-aligned) never requests memory.
  - The uop completes in 1 cycle with the GPR write suppressed and misaligned_o = 1 for that cycle.
  - Store byte enables never wrap past the bus width.
- Undefined:
  - No check; misaligned_o tied 0.
  - Address is aligned down; byte enables are truncated to the bus width.

Decomposition:
- exe2mem_pkg: exe2mem_t typedef.
- mem2wb_pkg: mem2wb_t typedef (existing).
- core_pkg: mem_ctrl encodings (size, sign, load/store) and the state enum mem_state_e {IDLE, REQ}.
- Sub-module memory_unit (combinational): computes d_m_be_o, d_m_wdata_o, d_m_addr_o and the misalignment flag from mem_ctrl, exe_out and op3.

Test Plan:
- ALU uop, rd = 5, exe_out = 0x1234 -> valid_o high the next cycle, mem2wb_o.rd = 5, d_m_req_o never high.
- Store word, addr 0x100, op3 = 0xDEADBEEF, grant held low 3 cycles -> d_m_req_o high 4 cycles with d_m_addr_o = 0x100, be = 0xF; ready_o low 3 cycles; valid_o high on the grant cycle.
- Store byte, addr 0x103, op3 = 0xAB, immediate grant -> be = 0x8, d_m_wdata_o = 0xAB000000, latency 1.
- Back-to-back load, ALU, load, all granted immediately -> valid_o high 3 consecutive cycles, no bubble, ready_o stays 1.
- rstn_i low during REQ wait -> d_m_req_o = 0, valid_o = 0, ready_o = 1 next cycle; a later grant is ignored.
- With MEM_MISALIGN_CHECK_EN: load half at 0x101 -> no request, misaligned_o = 1 and valid_o = 1 for 1 cycle, GPR write disabled.
